cplx_add_seq: RTL and testbench

Sequencing controller for the complex adder datapath. It accepts one complex operand pair per transaction over a valid/ready handshake, time-shares a single sign-magnitude adder between the real and imaginary parts, and returns a signed complex result to the display/formatting logic downstream. It also adds a subtract mode, a result sign bit, and a completed-operation counter.

---
 rtl/cplx_pkg.sv | 28 ++
 rtl/cplx_add_seq_if.sv | 31 +++
 rtl/sm_add6.sv | 40 ++++
 rtl/cplx_add_seq.sv | 128 ++++++++++++
 tb/tb_cplx_add_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_pkg.sv
// Shared constants, state encoding and payload types for the complex adder sequencer.
package cplx_pkg;

  localparam int unsigned MAG_W    = 5;
  localparam int unsigned OP_W     = MAG_W + 1;
  localparam int unsigned SUM_W    = MAG_W + 1;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SIGN_BIT = MAG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RE   = 2'd1,
    IM   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Captured complex operand, each part sign-magnitude.
  typedef struct packed {
    logic [OP_W-1:0] re;
    logic [OP_W-1:0] im;
  } cplx_t;

  // Flip the sign of a sign-magnitude value; negative zero becomes plain zero.
  function automatic logic [OP_W-1:0] neg_sm(input logic [OP_W-1:0] x);
    return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/cplx_add_seq_if.sv
// Operand/result handshake bundle between the producer, the sequencer and the consumer.
interface cplx_add_seq_if
  import cplx_pkg::*;
();

  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [OP_W-1:0]  a_re;
  logic [OP_W-1:0]  a_im;
  logic [OP_W-1:0]  b_re;
  logic [OP_W-1:0]  b_im;
  logic             out_valid;
  logic             out_ready;
  logic             re_sign;
  logic             im_sign;
  logic [SUM_W-1:0] re_mag;
  logic [SUM_W-1:0] im_mag;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output in_valid, in_sub, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, re_sign, im_sign, re_mag, im_mag, ops_done
  );

  modport slave (
    input  in_valid, in_sub, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, re_sign, im_sign, re_mag, im_mag, ops_done
  );

endinterface

// File: rtl/sm_add6.sv
// Combinational sign-magnitude adder; a zero result always carries a positive sign.
module sm_add6
  import cplx_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             sign_c,
  output logic [SUM_W-1:0] mag_c
);

  logic             sa;
  logic             sb;
  logic [MAG_W-1:0] ma;
  logic [MAG_W-1:0] mb;

  assign sa = a[SIGN_BIT];
  assign sb = b[SIGN_BIT];
  assign ma = a[SIGN_BIT-1:0];
  assign mb = b[SIGN_BIT-1:0];

  // Add magnitudes on matching signs, otherwise subtract the smaller from the larger.
  always_comb begin
    sign_c = 1'b0;
    mag_c  = '0;
    if (sa == sb) begin
      mag_c  = SUM_W'(ma) + SUM_W'(mb);
      sign_c = sa;
    end else if (ma > mb) begin
      mag_c  = SUM_W'(ma - mb);
      sign_c = sa;
    end else begin
      mag_c  = SUM_W'(mb - ma);
      sign_c = sb;
    end
    if (mag_c == '0) begin
      sign_c = 1'b0;
    end
  end

endmodule

// File: rtl/cplx_add_seq.sv
// Sequencer that time-shares one sign-magnitude adder across real and imaginary parts.
module cplx_add_seq
  import cplx_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cplx_add_seq_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  cplx_t            a_q;
  cplx_t            b_q;
  logic             re_sign_q;
  logic             im_sign_q;
  logic [SUM_W-1:0] re_mag_q;
  logic [SUM_W-1:0] im_mag_q;
  logic [CNT_W-1:0] ops_done_q;
  logic             accept_c;
  logic             handoff_c;
  logic [OP_W-1:0]  add_a_c;
  logic [OP_W-1:0]  add_b_c;
  logic             add_sign_c;
  logic [SUM_W-1:0] add_mag_c;

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    handoff_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_d  = RE;
        end
      end
      RE:   state_d = IM;
      IM:   state_d = DONE;
      DONE: begin
        if (bus.out_ready) begin
          handoff_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Operand capture; subtraction is folded in by negating B once at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept_c) begin
      a_q.re <= bus.a_re;
      a_q.im <= bus.a_im;
      b_q.re <= bus.in_sub ? neg_sm(bus.b_re) : bus.b_re;
      b_q.im <= bus.in_sub ? neg_sm(bus.b_im) : bus.b_im;
    end
  end

  // Shared adder input select: imaginary pair in IM, real pair otherwise.
  always_comb begin
    add_a_c = a_q.re;
    add_b_c = b_q.re;
    if (state_q == IM) begin
      add_a_c = a_q.im;
      add_b_c = b_q.im;
    end
  end

  sm_add6 u_add (
    .a      (add_a_c),
    .b      (add_b_c),
    .sign_c (add_sign_c),
    .mag_c  (add_mag_c)
  );

  // Result registers, loaded from the shared adder in RE and IM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sign_q <= 1'b0;
      re_mag_q  <= '0;
      im_sign_q <= 1'b0;
      im_mag_q  <= '0;
    end else if (state_q == RE) begin
      re_sign_q <= add_sign_c;
      re_mag_q  <= add_mag_c;
    end else if (state_q == IM) begin
      im_sign_q <= add_sign_c;
      im_mag_q  <= add_mag_c;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if (handoff_c) begin
      ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.re_sign   = re_sign_q;
  assign bus.re_mag    = re_mag_q;
  assign bus.im_sign   = im_sign_q;
  assign bus.im_mag    = im_mag_q;
  assign bus.ops_done  = ops_done_q;

endmodule

// File: tb/tb_cplx_add_seq.sv
// Directed self-checking bench for cplx_add_seq.
module tb_cplx_add_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_ops;

  cplx_add_seq_if bus ();

  cplx_add_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair at a negedge in IDLE and count negedges until out_valid.
  task automatic start_op(input logic [5:0] ar, input logic [5:0] ai, input logic [5:0] br,
                          input logic [5:0] bi, input logic sub, output int lat);
    bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi; bus.in_sub = sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_ops = (exp_ops + 1) % 256;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== 14'd0) begin
      n_fail++; $display("FAIL reset_results: got %h expected 0", {bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag});
    end
    n_checks++;
    if (bus.ops_done !== 8'd0) begin n_fail++; $display("FAIL reset_ops_done: got %0d expected 0", bus.ops_done); end
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_add();
    int lat;
    start_op(6'h03, 6'h04, 6'h05, 6'h26, 1'b0, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
    n_checks++;
    if ({bus.re_sign, bus.re_mag} !== {1'b0, 6'd8}) begin
      n_fail++; $display("FAIL add_re: got %b/%0d expected 0/8", bus.re_sign, bus.re_mag);
    end
    n_checks++;
    if ({bus.im_sign, bus.im_mag} !== {1'b1, 6'd2}) begin
      n_fail++; $display("FAIL add_im: got %b/%0d expected 1/2", bus.im_sign, bus.im_mag);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_ready: got %b expected 0", bus.in_ready); end
    handoff();
    n_checks++;
    if (bus.ops_done !== 8'(exp_ops)) begin n_fail++; $display("FAIL add_ops_done: got %0d expected %0d", bus.ops_done, exp_ops); end
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL add_after_handoff: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    start_op(6'h0A, 6'h27, 6'h0A, 6'h23, 1'b1, lat);
    n_checks++;
    if ({bus.re_sign, bus.re_mag} !== {1'b0, 6'd0}) begin
      n_fail++; $display("FAIL sub_re: got %b/%0d expected 0/0", bus.re_sign, bus.re_mag);
    end
    n_checks++;
    if ({bus.im_sign, bus.im_mag} !== {1'b1, 6'd4}) begin
      n_fail++; $display("FAIL sub_im: got %b/%0d expected 1/4", bus.im_sign, bus.im_mag);
    end
    handoff();
  endtask

  task automatic test_extremes();
    int lat;
    start_op(6'h3F, 6'h1F, 6'h3F, 6'h1F, 1'b0, lat);
    n_checks++;
    if ({bus.re_sign, bus.re_mag} !== {1'b1, 6'd62}) begin
      n_fail++; $display("FAIL ext_re_max: got %b/%0d expected 1/62", bus.re_sign, bus.re_mag);
    end
    n_checks++;
    if ({bus.im_sign, bus.im_mag} !== {1'b0, 6'd62}) begin
      n_fail++; $display("FAIL ext_im_max: got %b/%0d expected 0/62", bus.im_sign, bus.im_mag);
    end
    handoff();
    start_op(6'h3F, 6'h00, 6'h1F, 6'h00, 1'b0, lat);
    n_checks++;
    if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== 14'd0) begin
      n_fail++; $display("FAIL ext_cancel: got re=%b/%0d im=%b/%0d expected all 0", bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag);
    end
    handoff();
  endtask

  task automatic test_backpressure();
    int lat;
    int ops_before;
    start_op(6'h01, 6'h02, 6'h03, 6'h24, 1'b0, lat);
    ops_before = exp_ops;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a_re = 6'h1F; bus.b_re = 6'h1F; bus.a_im = 6'h3F; bus.b_im = 6'h3F;
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
        n_fail++; $display("FAIL bp_handshake[%0d]: got valid=%b ready=%b expected 1/0", i, bus.out_valid, bus.in_ready);
      end
      n_checks++;
      if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== {1'b0, 6'd4, 1'b1, 6'd2}) begin
        n_fail++; $display("FAIL bp_stable[%0d]: got re=%b/%0d im=%b/%0d expected 0/4 1/2", i, bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag);
      end
      n_checks++;
      if (bus.ops_done !== 8'(ops_before)) begin
        n_fail++; $display("FAIL bp_ops_hold[%0d]: got %0d expected %0d", i, bus.ops_done, ops_before);
      end
    end
    bus.in_valid = 1'b0;
    handoff();
    n_checks++;
    if (bus.ops_done !== 8'(ops_before + 1)) begin
      n_fail++; $display("FAIL bp_ops_inc: got %0d expected %0d", bus.ops_done, ops_before + 1);
    end
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.a_re = 6'h05; bus.a_im = 6'h05; bus.b_re = 6'h05; bus.b_im = 6'h05; bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== 14'd0) begin
      n_fail++; $display("FAIL mid_results: got re=%b/%0d im=%b/%0d expected all 0", bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag);
    end
    n_checks++;
    if (bus.ops_done !== 8'd0) begin n_fail++; $display("FAIL mid_ops_done: got %0d expected 0", bus.ops_done); end
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL mid_release: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    start_op(6'h05, 6'h05, 6'h05, 6'h05, 1'b0, lat);
    n_checks++;
    if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== {1'b0, 6'd10, 1'b0, 6'd10} || lat !== 3) begin
      n_fail++; $display("FAIL mid_next_op: got re=%b/%0d im=%b/%0d lat=%0d expected 0/10 0/10 lat 3", bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag, lat);
    end
    handoff();
    n_checks++;
    if (bus.ops_done !== 8'd1) begin n_fail++; $display("FAIL mid_next_ops: got %0d expected 1", bus.ops_done); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int handoffs;
    int last_acc;
    int spacing_err;
    pulse_reset();
    bus.a_re = 6'h20; bus.b_re = 6'h00; bus.a_im = 6'h11; bus.b_im = 6'h02; bus.in_sub = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    accepts = 0; handoffs = 0; last_acc = 0; spacing_err = 0;
    for (int c = 0; c < 1100 && handoffs < 256; c++) begin
      if (bus.in_ready) begin
        if (accepts > 0 && (c - last_acc) != 4) spacing_err++;
        last_acc = c;
        accepts++;
      end
      if (bus.out_valid) begin
        n_checks++;
        if (bus.ops_done !== 8'(handoffs % 256)) begin
          n_fail++; $display("FAIL b2b_ops_done[%0d]: got %0d expected %0d", handoffs, bus.ops_done, handoffs % 256);
        end
        n_checks++;
        if ({bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag} !== {1'b0, 6'd0, 1'b0, 6'd19}) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got re=%b/%0d im=%b/%0d expected 0/0 0/19", handoffs, bus.re_sign, bus.re_mag, bus.im_sign, bus.im_mag);
        end
        handoffs++;
        if (handoffs == 256) bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (handoffs !== 256 || accepts !== 256) begin
      n_fail++; $display("FAIL b2b_count: got handoffs=%0d accepts=%0d expected 256/256", handoffs, accepts);
    end
    n_checks++;
    if (spacing_err !== 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d irregular gaps expected 0", spacing_err); end
    n_checks++;
    if (bus.ops_done !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 0", bus.ops_done); end
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_idle: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ops  = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
